// File: rtl/uart_core_param.sv
// -----------------------------------------------------------------------------
// uart_core_param
// Full-duplex UART engine with a run-time configurable baud divisor, parity
// and stop-bit count, and a build-time word length and oversampling ratio.
// TX serialises words from a valid/ready handshake; RX deserialises the
// (synchronised) rx pin and emits a one-cycle valid pulse with error flags.
//
// Parameters
//   DATA_BITS   payload width, 5..9
//   DIV_WIDTH   width of clk_div
//   OVERSAMPLE  ticks per bit, even, >= 4
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   clk_div               tick period minus one
//   parity_en/parity_odd  parity enable / odd (1) or even (0)
//   two_stop              1 = two stop bits on TX
//   tx_valid/tx_ready     transmit handshake, tx_data word (LSB first)
//   rx_valid              one-cycle pulse, rx_data/error flags held until next
//   rx / tx               serial pins (rx asynchronous, tx idle high)
// -----------------------------------------------------------------------------
module uart_core_param #(
    parameter int DATA_BITS  = 8,
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [DIV_WIDTH-1:0] clk_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    input  logic                 rx,
    output logic                 tx
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------ TX
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_t;

    tx_state_t              tx_state_q;
    logic [DIV_WIDTH-1:0]   tx_div_q, tx_pre_q;
    logic [TICK_W-1:0]      tx_tick_q;
    logic [BIT_W-1:0]       tx_bit_q;
    logic [DATA_BITS-1:0]   tx_shift_q;
    logic                   tx_par_q, tx_par_en_q, tx_two_stop_q, tx_q;
    logic                   tx_tick, tx_bit_end, tx_frame_end, tx_accept;

    assign tx_tick      = (tx_pre_q == tx_div_q);
    assign tx_bit_end   = (tx_state_q != TX_IDLE) && tx_tick && (tx_tick_q == TICK_LAST);
    assign tx_frame_end = tx_bit_end &&
                          (((tx_state_q == TX_STOP1) && !tx_two_stop_q) || (tx_state_q == TX_STOP2));
    // Ready is also high in the final cycle of the last stop bit so a held
    // tx_valid starts the next frame with no idle gap.
    assign tx_ready     = (tx_state_q == TX_IDLE) || tx_frame_end;
    assign tx_accept    = tx_valid && tx_ready;
    assign tx           = tx_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop regardless of order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q    <= TX_IDLE;
            tx_div_q      <= '0;
            tx_pre_q      <= '0;
            tx_tick_q     <= '0;
            tx_bit_q      <= '0;
            tx_shift_q    <= '0;
            tx_par_q      <= 1'b0;
            tx_par_en_q   <= 1'b0;
            tx_two_stop_q <= 1'b0;
            tx_q          <= 1'b1;
        end else if (tx_accept) begin
            tx_state_q    <= TX_START;
            tx_div_q      <= clk_div;
            tx_par_en_q   <= parity_en;
            tx_two_stop_q <= two_stop;
            tx_par_q      <= (^tx_data) ^ parity_odd;
            tx_shift_q    <= tx_data;
            tx_bit_q      <= '0;
            tx_pre_q      <= '0;
            tx_tick_q     <= '0;
            tx_q          <= 1'b0;
        end else if (tx_state_q != TX_IDLE) begin
            if (tx_tick) begin
                tx_pre_q  <= '0;
                tx_tick_q <= (tx_tick_q == TICK_LAST) ? '0 : tx_tick_q + 1'b1;
            end else begin
                tx_pre_q  <= tx_pre_q + 1'b1;
            end
            if (tx_bit_end) begin
                case (tx_state_q)
                    TX_START: begin
                        tx_state_q <= TX_DATA;
                        tx_q       <= tx_shift_q[0];
                    end
                    TX_DATA: begin
                        if (tx_bit_q == BIT_LAST) begin
                            tx_state_q <= tx_par_en_q ? TX_PARITY : TX_STOP1;
                            tx_q       <= tx_par_en_q ? tx_par_q : 1'b1;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 1'b1;
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_q       <= tx_shift_q[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state_q <= TX_STOP1;
                        tx_q       <= 1'b1;
                    end
                    TX_STOP1: tx_state_q <= tx_two_stop_q ? TX_STOP2 : TX_IDLE;
                    default:  tx_state_q <= TX_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------ RX
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    rx_state_t              rx_state_q;
    logic                   rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_WIDTH-1:0]   rx_div_q, rx_pre_q;
    logic [TICK_W-1:0]      rx_tick_q;
    logic [BIT_W-1:0]       rx_bit_q;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_data_q;
    logic                   rx_par_en_q, rx_par_odd_q, rx_par_acc_q, rx_break_q;
    logic                   rx_valid_q, rx_perr_q, rx_ferr_q;
    logic                   rx_fall, rx_tick, rx_sample;

    assign rx_fall   = rx_prev_q && !rx_sync_q;
    assign rx_tick   = (rx_pre_q == rx_div_q);
    // The start bit is checked half a bit in; every later bit one full bit after.
    assign rx_sample = (rx_state_q != RX_IDLE) && rx_tick &&
                       (rx_tick_q == ((rx_state_q == RX_START) ? TICK_MID : TICK_LAST));

    assign rx_valid      = rx_valid_q;
    assign rx_data       = rx_data_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_q   <= RX_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_div_q     <= '0;
            rx_pre_q     <= '0;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_data_q    <= '0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            rx_par_acc_q <= 1'b0;
            rx_break_q   <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_perr_q    <= 1'b0;
            rx_ferr_q    <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_valid_q <= 1'b0;
            if (rx_state_q == RX_IDLE) begin
                // After a frame error, wait for the line to read 1 so a held
                // break cannot start another frame.
                if (rx_break_q) begin
                    if (rx_sync_q) rx_break_q <= 1'b0;
                end else if (rx_fall) begin
                    rx_state_q   <= RX_START;
                    rx_div_q     <= clk_div;
                    rx_par_en_q  <= parity_en;
                    rx_par_odd_q <= parity_odd;
                    rx_pre_q     <= '0;
                    rx_tick_q    <= '0;
                    rx_bit_q     <= '0;
                    rx_par_acc_q <= 1'b0;
                end
            end else begin
                if (rx_tick) begin
                    rx_pre_q  <= '0;
                    rx_tick_q <= rx_sample ? '0 : rx_tick_q + 1'b1;
                end else begin
                    rx_pre_q  <= rx_pre_q + 1'b1;
                end
                if (rx_sample) begin
                    case (rx_state_q)
                        RX_START: rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                        RX_DATA: begin
                            rx_shift_q   <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                            rx_par_acc_q <= rx_par_acc_q ^ rx_sync_q;
                            if (rx_bit_q == BIT_LAST)
                                rx_state_q <= rx_par_en_q ? RX_PARITY : RX_STOP;
                            else
                                rx_bit_q <= rx_bit_q + 1'b1;
                        end
                        RX_PARITY: begin
                            // Accumulator becomes the mismatch flag.
                            rx_par_acc_q <= rx_par_acc_q ^ rx_sync_q ^ rx_par_odd_q;
                            rx_state_q   <= RX_STOP;
                        end
                        default: begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_shift_q;
                            rx_perr_q  <= rx_par_en_q && rx_par_acc_q;
                            rx_ferr_q  <= !rx_sync_q;
                            rx_break_q <= !rx_sync_q;
                            rx_state_q <= RX_IDLE;
                        end
                    endcase
                end
            end
        end
    end

endmodule
